noc_flit_injector: RTL and testbench

//   Network-interface transmitter feeding a mesh router input port; the source end of the dest_x/dest_y routing interface.

---
 rtl/noc_flit_injector.sv | 203 ++++++++++++++++++++
 tb/tb_noc_flit_injector.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_flit_injector.sv
// noc_flit_injector
//   Network-interface transmitter at the source end of a mesh router input
//   port. Each accepted packet request (destination + body length) becomes one
//   head flit carrying the destination, followed by req_len body flits that
//   carry payload words. Flits are only sent while the downstream input buffer
//   has space, tracked by a credit counter.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready        packet request handshake
//   req_dest_x/req_dest_y      destination coordinates for the head flit
//   req_len                    body flit count (0 = head-only packet)
//   pay_valid/pay_ready        payload word handshake
//   pay_data                   payload word for the next body flit
//   flit_valid                 one-cycle pulse per flit sent (registered)
//   flit_head/flit_tail        flit is first / last of its packet
//   flit_dest_x/flit_dest_y    destination, updated on head flits, else held
//   flit_data                  payload on body flits, 0 on head flits
//   credit_in                  downstream freed one buffer slot
//   credits                    current credit count
//   busy                       packet in progress
//   err_credit                 sticky: credit returned while counter was full
module noc_flit_injector #(
    parameter int COORD_W = 30,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int CREDITS = 4,
    parameter int CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_dest_x,
    input  logic [COORD_W-1:0] req_dest_y,
    input  logic [LEN_W-1:0]   req_len,
    input  logic               pay_valid,
    output logic               pay_ready,
    input  logic [DATA_W-1:0]  pay_data,
    output logic               flit_valid,
    output logic               flit_head,
    output logic               flit_tail,
    output logic [COORD_W-1:0] flit_dest_x,
    output logic [COORD_W-1:0] flit_dest_y,
    output logic [DATA_W-1:0]  flit_data,
    input  logic               credit_in,
    output logic [CNT_W-1:0]   credits,
    output logic               busy,
    output logic               err_credit
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CREDITS_MAX = CNT_W'(CREDITS);

    state_t               r_state;
    state_t               w_next_state;

    logic [COORD_W-1:0]   r_dest_x;
    logic [COORD_W-1:0]   r_dest_y;
    // Holds req_len while in HEAD, then counts remaining body flits in BODY.
    logic [LEN_W-1:0]     r_remaining;

    logic [CNT_W-1:0]     r_credits;
    logic                 r_err_credit;

    logic                 r_flit_valid;
    logic                 r_flit_head;
    logic                 r_flit_tail;
    logic [COORD_W-1:0]   r_flit_dest_x;
    logic [COORD_W-1:0]   r_flit_dest_y;
    logic [DATA_W-1:0]    r_flit_data;

    logic                 w_have_credit;
    logic                 w_accept;
    logic                 w_send;
    logic                 w_send_head;
    logic                 w_send_tail;

    // Credit availability is judged on the registered count only, so a
    // credit returned this cycle cannot enable a send from zero.
    assign w_have_credit = (r_credits != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        pay_ready    = 1'b0;
        w_accept     = 1'b0;
        w_send       = 1'b0;
        w_send_head  = 1'b0;
        w_send_tail  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_HEAD;
                end
            end
            S_HEAD: begin
                if (w_have_credit) begin
                    w_send       = 1'b1;
                    w_send_head  = 1'b1;
                    w_send_tail  = (r_remaining == '0);
                    w_next_state = (r_remaining == '0) ? S_IDLE : S_BODY;
                end
            end
            S_BODY: begin
                pay_ready = w_have_credit;
                if (pay_valid && w_have_credit) begin
                    w_send      = 1'b1;
                    w_send_tail = (r_remaining == LEN_W'(1));
                    if (r_remaining == LEN_W'(1)) begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Latched request and body countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dest_x    <= '0;
            r_dest_y    <= '0;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_dest_x    <= req_dest_x;
            r_dest_y    <= req_dest_y;
            r_remaining <= req_len;
        end else if (w_send && !w_send_head) begin
            r_remaining <= r_remaining - LEN_W'(1);
        end
    end

    // Credit counter: send and return in the same cycle cancel out; a return
    // into a full counter is a protocol error and is flagged, not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits    <= CREDITS_MAX;
            r_err_credit <= 1'b0;
        end else begin
            if (w_send && !credit_in) begin
                r_credits <= r_credits - CNT_W'(1);
            end else if (!w_send && credit_in) begin
                if (r_credits == CREDITS_MAX) begin
                    r_err_credit <= 1'b1;
                end else begin
                    r_credits <= r_credits + CNT_W'(1);
                end
            end
        end
    end

    // Registered flit outputs; fields other than flit_valid hold between flits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flit_valid  <= 1'b0;
            r_flit_head   <= 1'b0;
            r_flit_tail   <= 1'b0;
            r_flit_dest_x <= '0;
            r_flit_dest_y <= '0;
            r_flit_data   <= '0;
        end else begin
            r_flit_valid <= w_send;
            if (w_send) begin
                r_flit_head <= w_send_head;
                r_flit_tail <= w_send_tail;
                r_flit_data <= w_send_head ? '0 : pay_data;
                if (w_send_head) begin
                    r_flit_dest_x <= r_dest_x;
                    r_flit_dest_y <= r_dest_y;
                end
            end
        end
    end

    assign flit_valid  = r_flit_valid;
    assign flit_head   = r_flit_head;
    assign flit_tail   = r_flit_tail;
    assign flit_dest_x = r_flit_dest_x;
    assign flit_dest_y = r_flit_dest_y;
    assign flit_data   = r_flit_data;
    assign credits     = r_credits;
    assign err_credit  = r_err_credit;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_noc_flit_injector.sv
// Testbench for noc_flit_injector: directed packet scenarios with literal
// expectations, plus a packet-level model compared against the DUT every cycle.
module tb_noc_flit_injector;

    localparam int COORD_W = 30;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 4;
    localparam int CREDITS = 4;
    localparam int CNT_W   = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [COORD_W-1:0] req_dest_x = '0;
    logic [COORD_W-1:0] req_dest_y = '0;
    logic [LEN_W-1:0]   req_len = '0;
    logic               pay_valid = 1'b0;
    logic               pay_ready;
    logic [DATA_W-1:0]  pay_data = '0;
    logic               flit_valid;
    logic               flit_head;
    logic               flit_tail;
    logic [COORD_W-1:0] flit_dest_x;
    logic [COORD_W-1:0] flit_dest_y;
    logic [DATA_W-1:0]  flit_data;
    logic               credit_in = 1'b0;
    logic [CNT_W-1:0]   credits;
    logic               busy;
    logic               err_credit;

    int n_checks = 0;
    int n_errors = 0;

    noc_flit_injector #(
        .COORD_W (COORD_W),
        .DATA_W  (DATA_W),
        .LEN_W   (LEN_W),
        .CREDITS (CREDITS),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dest_x  (req_dest_x),
        .req_dest_y  (req_dest_y),
        .req_len     (req_len),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .pay_data    (pay_data),
        .flit_valid  (flit_valid),
        .flit_head   (flit_head),
        .flit_tail   (flit_tail),
        .flit_dest_x (flit_dest_x),
        .flit_dest_y (flit_dest_y),
        .flit_data   (flit_data),
        .credit_in   (credit_in),
        .credits     (credits),
        .busy        (busy),
        .err_credit  (err_credit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model ----------------
    // m_left: flits of the current packet still to send (0 = no packet).
    // m_sent: flits of the current packet already sent (0 = head still owed).
    int                 m_left = 0;
    int                 m_sent = 0;
    int                 m_credits = CREDITS;
    bit                 m_err = 1'b0;
    logic [COORD_W-1:0] m_dx = '0;
    logic [COORD_W-1:0] m_dy = '0;
    bit                 e_valid = 1'b0;
    bit                 e_head = 1'b0;
    bit                 e_tail = 1'b0;
    logic [DATA_W-1:0]  e_data = '0;
    logic [COORD_W-1:0] e_dx = '0;
    logic [COORD_W-1:0] e_dy = '0;

    // Inputs change just after posedge, so at negedge they equal what the
    // next posedge will sample.
    always @(negedge clk) begin
        bit send;
        if (!rst_n) begin
            m_left = 0; m_sent = 0; m_credits = CREDITS; m_err = 1'b0;
            m_dx = '0; m_dy = '0;
            e_valid = 1'b0; e_head = 1'b0; e_tail = 1'b0;
            e_data = '0; e_dx = '0; e_dy = '0;
            chk("m_rst_valid", flit_valid, 0);
            chk("m_rst_head", flit_head, 0);
            chk("m_rst_tail", flit_tail, 0);
            chk("m_rst_data", flit_data, 0);
            chk("m_rst_dx", flit_dest_x, 0);
            chk("m_rst_dy", flit_dest_y, 0);
            chk("m_rst_credits", credits, CREDITS);
            chk("m_rst_busy", busy, 0);
            chk("m_rst_err", err_credit, 0);
        end else begin
            chk("m_req_ready", req_ready, (m_left == 0));
            chk("m_busy", busy, (m_left > 0));
            chk("m_pay_ready", pay_ready, (m_left > 0 && m_sent > 0 && m_credits > 0));
            chk("m_credits", credits, 64'(m_credits));
            chk("m_err", err_credit, m_err);
            chk("m_flit_valid", flit_valid, e_valid);
            chk("m_dest_x", flit_dest_x, e_dx);
            chk("m_dest_y", flit_dest_y, e_dy);
            if (e_valid) begin
                chk("m_flit_head", flit_head, e_head);
                chk("m_flit_tail", flit_tail, e_tail);
                chk("m_flit_data", flit_data, e_data);
            end

            send = (m_left > 0) && (m_credits > 0) && (m_sent == 0 || pay_valid);
            e_valid = send;
            if (send) begin
                e_head = (m_sent == 0);
                e_tail = (m_left == 1);
                e_data = (m_sent == 0) ? '0 : pay_data;
                if (m_sent == 0) begin
                    e_dx = m_dx;
                    e_dy = m_dy;
                end
            end

            if (send && !credit_in) begin
                m_credits = m_credits - 1;
            end else if (!send && credit_in) begin
                if (m_credits == CREDITS) m_err = 1'b1;
                else m_credits = m_credits + 1;
            end

            if (send) begin
                m_left = m_left - 1;
                m_sent = m_sent + 1;
            end else if (m_left == 0 && req_valid) begin
                m_left = int'(req_len) + 1;
                m_sent = 0;
                m_dx = req_dest_x;
                m_dy = req_dest_y;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input int dx, input int dy, input int len);
        req_valid  = 1'b1;
        req_dest_x = COORD_W'(dx);
        req_dest_y = COORD_W'(dy);
        req_len    = LEN_W'(len);
    endtask

    task automatic credit_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            credit_in = 1'b1;
            tick();
        end
        credit_in = 1'b0;
    endtask

    initial begin
        int cnt;

        tick(); tick();
        chk("reset_credits", credits, 4);
        chk("reset_req_ready", req_ready, 1);
        rst_n = 1'b1;
        tick();

        // Packet 5/3 len 2, payload always valid.
        request(5, 3, 2); pay_valid = 1'b1; pay_data = 32'h000000A1;
        tick();
        req_valid = 1'b0;
        chk("p1_busy", busy, 1);
        chk("p1_req_ready", req_ready, 0);
        chk("p1_no_flit_t1", flit_valid, 0);
        tick();
        chk("p1_head_valid", flit_valid, 1);
        chk("p1_head", flit_head, 1);
        chk("p1_head_tail", flit_tail, 0);
        chk("p1_head_dx", flit_dest_x, 5);
        chk("p1_head_dy", flit_dest_y, 3);
        chk("p1_head_data", flit_data, 0);
        tick();
        chk("p1_b1_valid", flit_valid, 1);
        chk("p1_b1_head", flit_head, 0);
        chk("p1_b1_data", flit_data, 32'hA1);
        chk("p1_b1_tail", flit_tail, 0);
        pay_data = 32'h000000B2;
        tick();
        chk("p1_b2_valid", flit_valid, 1);
        chk("p1_b2_data", flit_data, 32'hB2);
        chk("p1_b2_tail", flit_tail, 1);
        chk("p1_credits", credits, 1);
        pay_valid = 1'b0;
        tick();
        chk("p1_done_valid", flit_valid, 0);
        chk("p1_done_busy", busy, 0);
        credit_pulses(3);

        // Head-only packet to 0/0.
        request(0, 0, 0);
        tick();
        req_valid = 1'b0;
        tick();
        chk("p2_valid", flit_valid, 1);
        chk("p2_head", flit_head, 1);
        chk("p2_tail", flit_tail, 1);
        chk("p2_data", flit_data, 0);
        chk("p2_dx", flit_dest_x, 0);
        chk("p2_busy", busy, 0);
        chk("p2_req_ready", req_ready, 1);
        credit_pulses(1);

        // Credit exhaustion with len 7.
        request(2, 1, 7); pay_valid = 1'b1; pay_data = 32'hC0DE0007;
        tick();
        req_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (flit_valid) cnt++;
            tick();
        end
        chk("p3_flits_before_stall", cnt, 4);
        chk("p3_stall_pay_ready", pay_ready, 0);
        chk("p3_stall_credits", credits, 0);
        chk("p3_stall_busy", busy, 1);
        credit_pulses(1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (flit_valid) cnt++;
            tick();
        end
        chk("p3_one_more_flit", cnt, 1);
        for (int i = 0; i < 40 && busy; i++) begin
            credit_in = 1'b1;
            tick();
        end
        credit_in = 1'b0;
        pay_valid = 1'b0;
        chk("p3_finished", busy, 0);
        for (int i = 0; i < 10 && credits < 3'(CREDITS); i++) begin
            credit_in = 1'b1;
            tick();
        end
        credit_in = 1'b0;
        tick();
        chk("p3_restored", credits, 4);
        chk("p3_no_err", err_credit, 0);

        // Send and credit return together at credits=2.
        request(1, 2, 3); pay_valid = 1'b1; pay_data = 32'h00000033;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("p4_credits_hold", credits, 2);
        chk("p4_flit_valid", flit_valid, 1);
        chk("p4_flit_tail", flit_tail, 0);
        tick();
        chk("p4_tail", flit_tail, 1);
        chk("p4_credits_after", credits, 1);
        pay_valid = 1'b0;
        tick();
        credit_pulses(3);

        // Surplus credit while idle and full.
        chk("p5_full", credits, 4);
        credit_pulses(1);
        chk("p5_credits", credits, 4);
        chk("p5_err", err_credit, 1);
        tick(); tick(); tick();
        chk("p5_err_sticky", err_credit, 1);

        // Reset mid-packet after two body flits.
        request(7, 9, 5); pay_valid = 1'b1; pay_data = 32'h00000066;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("p6_b2_valid", flit_valid, 1);
        chk("p6_b2_credits", credits, 1);
        rst_n = 1'b0;
        pay_valid = 1'b0;
        #1;
        chk("p6_rst_valid", flit_valid, 0);
        chk("p6_rst_data", flit_data, 0);
        chk("p6_rst_dx", flit_dest_x, 0);
        chk("p6_rst_credits", credits, 4);
        chk("p6_rst_busy", busy, 0);
        chk("p6_rst_err", err_credit, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Normal len 1 packet after reset.
        request(3, 4, 1); pay_valid = 1'b1; pay_data = 32'h00000055;
        tick();
        req_valid = 1'b0;
        tick();
        chk("p7_head", flit_head, 1);
        chk("p7_head_dx", flit_dest_x, 3);
        chk("p7_head_dy", flit_dest_y, 4);
        chk("p7_head_tail", flit_tail, 0);
        tick();
        chk("p7_body_valid", flit_valid, 1);
        chk("p7_body_data", flit_data, 32'h55);
        chk("p7_body_tail", flit_tail, 1);
        pay_valid = 1'b0;
        tick(); tick(); tick();
        chk("p7_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
